cp_rf_mp: RTL and testbench

CP_RF_MP -- requirements
Module: cp_rf_mp

---
 rtl/cp_rf_mp_pkg.sv | 14 +
 rtl/cp_rf_rdport.sv | 50 +++++
 rtl/cp_rf_mp.sv | 133 +++++++++++++
 tb/tb_cp_rf_mp.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cp_rf_mp_pkg.sv
// Shared types and default geometry for the cp_rf_mp multi-port register file.
package cp_rf_mp_pkg;

   localparam int CP_RF_DATA_WIDTH = 32;
   localparam int CP_RF_DEPTH      = 28;
   localparam int CP_RF_NUM_RD     = 2;
   localparam int CP_RF_ADDR_WIDTH = 5;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

endpackage : cp_rf_mp_pkg

// File: rtl/cp_rf_rdport.sv
// One combinational read port: address decode, range check, optional write-first
// bypass (enabled by defining CP_RF_BYPASS_EN).
module cp_rf_rdport
   import cp_rf_mp_pkg::*;
#(
   parameter int DATA_WIDTH = CP_RF_DATA_WIDTH,
   parameter int DEPTH      = CP_RF_DEPTH,
   parameter int ADDR_WIDTH = CP_RF_ADDR_WIDTH
) (
   input  logic [ADDR_WIDTH-1:0]             iRd_Addr,
   input  logic [(DEPTH-1)*DATA_WIDTH-1:0]   iMem,
`ifdef CP_RF_BYPASS_EN
   input  logic                              iWr_Commit,
   input  logic [ADDR_WIDTH-1:0]             iWr_Addr,
   input  logic [DATA_WIDTH-1:0]             iWr_Data,
`endif
   output logic [DATA_WIDTH-1:0]             oRd_Data,
   output logic                              oOor
);

   localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] rdata_s;

   // AND-OR mux over entries 1..DEPTH-1; address 0 and out-of-range hit nothing
   always_comb begin
      rdata_s = '0;
      for (int i = 1; i < DEPTH; i++) begin
         rdata_s = rdata_s
                 | ({DATA_WIDTH{iRd_Addr == ADDR_WIDTH'(i)}}
                    & iMem[(i-1)*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   assign oOor = ({1'b0, iRd_Addr} >= DEPTH_W);

`ifdef CP_RF_BYPASS_EN
   // iWr_Commit already excludes address 0, out-of-range and dropped writes
   always_comb begin
      if (iWr_Commit && (iWr_Addr == iRd_Addr)) begin
         oRd_Data = iWr_Data;
      end else begin
         oRd_Data = rdata_s;
      end
   end
`else
   assign oRd_Data = rdata_s;
`endif

endmodule : cp_rf_rdport

// File: rtl/cp_rf_mp.sv
// Multi-read-port register file with hardware clear sweep and sticky address error.
// Optional macro CP_RF_BYPASS_EN makes same-cycle reads of a committing write write-first.
module cp_rf_mp
   import cp_rf_mp_pkg::*;
#(
   parameter int DATA_WIDTH = CP_RF_DATA_WIDTH,
   parameter int DEPTH      = CP_RF_DEPTH,
   parameter int NUM_RD     = CP_RF_NUM_RD,
   parameter int ADDR_WIDTH = CP_RF_ADDR_WIDTH
) (
   input  logic                           iClk,
   input  logic                           iRst_n,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   iRd_Addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   oRd_Data,
   input  logic [ADDR_WIDTH-1:0]          iWr_Addr,
   input  logic [DATA_WIDTH-1:0]          iWr_Data,
   input  logic                           iWr_Enable,
   input  logic                           iClear,
   output logic                           oBusy,
   output logic                           oAddr_Err
);

   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH-1);

   if ((2**ADDR_WIDTH) < DEPTH) begin : g_bad_cfg
      $error("cp_rf_mp: ADDR_WIDTH too small for DEPTH");
   end

   state_e                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]           cnt_q, cnt_d;
   logic                            err_q, err_d;
   logic                            clr_we_s;
   logic                            wr_commit_s;
   logic                            wr_oor_s;
   logic [NUM_RD-1:0]               rd_oor_s;
   logic [DATA_WIDTH-1:0]           mem_q [1:DEPTH-1];
   logic [(DEPTH-1)*DATA_WIDTH-1:0] mem_flat_s;

   assign wr_commit_s = iWr_Enable && (state_q == IDLE)
                        && (iWr_Addr != {ADDR_WIDTH{1'b0}})
                        && ({1'b0, iWr_Addr} < DEPTH_W);
   assign wr_oor_s    = iWr_Enable && ({1'b0, iWr_Addr} >= DEPTH_W);

   // Clear-sweep FSM next state; iClear is ignored while a sweep runs
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_we_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (iClear) begin
               state_d = CLEAR;
               cnt_d   = ADDR_WIDTH'(1);
            end else begin
               state_d = IDLE;
            end
         end
         CLEAR: begin
            clr_we_s = 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
         end
         default: begin
            state_d = CLEAR;
            cnt_d   = ADDR_WIDTH'(1);
         end
      endcase
   end

   // Sticky address error, wiped on entry to a clear sweep
   always_comb begin
      if ((state_q == IDLE) && iClear) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q | wr_oor_s | (|rd_oor_s);
      end
   end

   // Control registers; reset lands in CLEAR so storage is swept after power-up
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= CLEAR;
         cnt_q   <= ADDR_WIDTH'(1);
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Storage has no reset; the sweep owns the write port while busy
   always_ff @(posedge iClk) begin
      if (clr_we_s) begin
         mem_q[cnt_q] <= '0;
      end else if (wr_commit_s) begin
         mem_q[iWr_Addr] <= iWr_Data;
      end
   end

   always_comb begin
      mem_flat_s = '0;
      for (int i = 1; i < DEPTH; i++) begin
         mem_flat_s[(i-1)*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      cp_rf_rdport #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_rdport (
         .iRd_Addr   (iRd_Addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
         .iMem       (mem_flat_s),
`ifdef CP_RF_BYPASS_EN
         .iWr_Commit (wr_commit_s),
         .iWr_Addr   (iWr_Addr),
         .iWr_Data   (iWr_Data),
`endif
         .oRd_Data   (oRd_Data[g*DATA_WIDTH +: DATA_WIDTH]),
         .oOor       (rd_oor_s[g])
      );
   end

   assign oBusy     = (state_q == CLEAR);
   assign oAddr_Err = err_q;

endmodule : cp_rf_mp

// File: tb/tb_cp_rf_mp.sv
// Directed self-checking bench for cp_rf_mp (default parameters, two read ports).
module tb_cp_rf_mp;

   logic        iClk;
   logic        iRst_n;
   logic [9:0]  iRd_Addr;
   logic [63:0] oRd_Data;
   logic [4:0]  iWr_Addr;
   logic [31:0] iWr_Data;
   logic        iWr_Enable;
   logic        iClear;
   logic        oBusy;
   logic        oAddr_Err;

   int total;
   int bad;
   int n;

   cp_rf_mp dut (
      .iClk       (iClk),
      .iRst_n     (iRst_n),
      .iRd_Addr   (iRd_Addr),
      .oRd_Data   (oRd_Data),
      .iWr_Addr   (iWr_Addr),
      .iWr_Data   (iWr_Data),
      .iWr_Enable (iWr_Enable),
      .iClear     (iClear),
      .oBusy      (oBusy),
      .oAddr_Err  (oAddr_Err)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      iRd_Addr = {a1, a0};
      #1;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (oBusy && cnt < 100) begin
         tick();
         cnt++;
      end
   endtask

   initial begin
      logic [31:0] same_cycle_exp;
      total      = 0;
      bad        = 0;
      iRst_n     = 1'b1;
      iRd_Addr   = 10'd0;
      iWr_Addr   = 5'd0;
      iWr_Data   = 32'd0;
      iWr_Enable = 1'b0;
      iClear     = 1'b0;
      #2 iRst_n  = 1'b0;
      #1;
      chk("rst_busy", {31'd0, oBusy}, 32'd1);
      chk("rst_err",  {31'd0, oAddr_Err}, 32'd0);
      tick();
      tick();
      iRst_n = 1'b1;

      // post-reset sweep length and contents
      wait_idle(n);
      chk("rst_sweep_len", n, 32'd27);
      chk("idle_busy", {31'd0, oBusy}, 32'd0);
      for (int i = 1; i < 28; i++) begin
         rd(5'(i), 5'(28 - i));
         chk("rst_zero_p0", oRd_Data[31:0],  32'd0);
         chk("rst_zero_p1", oRd_Data[63:32], 32'd0);
      end

      // write r5, same-cycle and next-cycle reads
`ifdef CP_RF_BYPASS_EN
      same_cycle_exp = 32'hDEADBEEF;
`else
      same_cycle_exp = 32'h0000_0000;
`endif
      iWr_Enable = 1'b1;
      iWr_Addr   = 5'd5;
      iWr_Data   = 32'hDEADBEEF;
      rd(5'd5, 5'd5);
      chk("r5_same_cycle", oRd_Data[31:0], same_cycle_exp);
      tick();
      iWr_Enable = 1'b0;
      #1;
      chk("r5_p0", oRd_Data[31:0],  32'hDEADBEEF);
      chk("r5_p1", oRd_Data[63:32], 32'hDEADBEEF);

      // write r0 is dropped silently
      iWr_Enable = 1'b1;
      iWr_Addr   = 5'd0;
      iWr_Data   = 32'h0000_1234;
      rd(5'd0, 5'd5);
      chk("r0_same_cycle", oRd_Data[31:0], 32'd0);
      tick();
      iWr_Enable = 1'b0;
      #1;
      chk("r0_read", oRd_Data[31:0], 32'd0);
      chk("r0_err",  {31'd0, oAddr_Err}, 32'd0);
      chk("r5_kept", oRd_Data[63:32], 32'hDEADBEEF);

      // out-of-range write r28
      iWr_Enable = 1'b1;
      iWr_Addr   = 5'd28;
      iWr_Data   = 32'h0000_AAAA;
      #1;
      chk("r28_err_before", {31'd0, oAddr_Err}, 32'd0);
      tick();
      iWr_Enable = 1'b0;
      #1;
      chk("r28_err_set", {31'd0, oAddr_Err}, 32'd1);
      rd(5'd28, 5'd27);
      chk("r28_read", oRd_Data[31:0], 32'd0);
      chk("r27_untouched", oRd_Data[63:32], 32'd0);
      rd(5'd0, 5'd0);
      tick();
      chk("err_sticky", {31'd0, oAddr_Err}, 32'd1);
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      #1;
      chk("clr_err", {31'd0, oAddr_Err}, 32'd0);
      chk("clr_busy", {31'd0, oBusy}, 32'd1);
      wait_idle(n);
      chk("clr_sweep_len", n, 32'd27);

      // fill r1..r27 with own index
      for (int i = 1; i < 28; i++) begin
         iWr_Enable = 1'b1;
         iWr_Addr   = 5'(i);
         iWr_Data   = 32'(i);
         tick();
      end
      iWr_Enable = 1'b0;
      rd(5'd1, 5'd27);
      chk("fill_r1",  oRd_Data[31:0],  32'd1);
      chk("fill_r27", oRd_Data[63:32], 32'd27);

      // clear sweep with write and restart attempts in cycle 5
      iClear = 1'b1;
      tick();
      iClear = 1'b0;
      tick();
      tick();
      tick();
      tick();
      rd(5'd3, 5'd20);
      chk("mid_busy", {31'd0, oBusy}, 32'd1);
      chk("mid_r3_zeroed", oRd_Data[31:0], 32'd0);
      chk("mid_r20_old",   oRd_Data[63:32], 32'd20);
      iWr_Enable = 1'b1;
      iWr_Addr   = 5'd3;
      iWr_Data   = 32'h0000_00FF;
      iClear     = 1'b1;
      tick();
      iWr_Enable = 1'b0;
      iClear     = 1'b0;
      wait_idle(n);
      chk("mid_sweep_rest", n, 32'd22);
      for (int i = 1; i < 28; i++) begin
         rd(5'(i), 5'(i));
         chk("swept_p0", oRd_Data[31:0],  32'd0);
         chk("swept_p1", oRd_Data[63:32], 32'd0);
      end

      // reset in sweep cycle 10 restarts the full sweep
      iWr_Enable = 1'b1;
      iWr_Addr   = 5'd27;
      iWr_Data   = 32'h0000_5A5A;
      tick();
      iWr_Enable = 1'b0;
      iClear     = 1'b1;
      tick();
      iClear = 1'b0;
      for (int i = 0; i < 9; i++) tick();
      chk("pre_rst_busy", {31'd0, oBusy}, 32'd1);
      iRst_n = 1'b0;
      #1;
      chk("mid_rst_busy", {31'd0, oBusy}, 32'd1);
      chk("mid_rst_err",  {31'd0, oAddr_Err}, 32'd0);
      tick();
      iRst_n = 1'b1;
      wait_idle(n);
      chk("rst_restart_len", n, 32'd27);
      rd(5'd27, 5'd10);
      chk("rst_r27_zero", oRd_Data[31:0],  32'd0);
      chk("rst_r10_zero", oRd_Data[63:32], 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cp_rf_mp
